// File: rtl/pwm_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pwm_capture
// Purpose  : Measures high time and period of an incoming PWM line in sample
//            ticks; reports a stuck-line result after a period of inactivity.
// Revision : 1.0  initial release
// ============================================================================
module pwm_capture #(
   parameter int RESOLUTION_BITS = 8,
   parameter int TIMEOUT_TICKS   = 511
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pwm_in,
   input  logic                       sample_ena,
   output logic [RESOLUTION_BITS-1:0] duty_out,
   output logic [RESOLUTION_BITS:0]   period_out,
   output logic                       rdy,
   output logic                       stuck,
   output logic                       level
);

   localparam int              CW         = $clog2(TIMEOUT_TICKS + 1);
   localparam int              c_DUTY_MAX = (1 << RESOLUTION_BITS) - 1;
   localparam int              c_PER_MAX  = (1 << (RESOLUTION_BITS + 1)) - 1;
   localparam logic [CW-1:0]   c_CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]   c_TMO_LAST = CW'(TIMEOUT_TICKS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2
   } state_t;

   logic                       r_sync;
   logic                       r_level;
   logic                       r_prev;
   state_t                     r_state;
   logic [CW-1:0]              r_per_cnt;
   logic [CW-1:0]              r_hi_cnt;
   logic [RESOLUTION_BITS-1:0] r_duty;
   logic [RESOLUTION_BITS:0]   r_period;
   logic                       r_rdy;
   logic                       r_stuck;

   state_t                     w_state_nxt;
   logic                       w_prev_nxt;
   logic [CW-1:0]              w_per_nxt;
   logic [CW-1:0]              w_hi_nxt;
   logic [RESOLUTION_BITS-1:0] w_duty_nxt;
   logic [RESOLUTION_BITS:0]   w_period_nxt;
   logic                       w_rdy_nxt;
   logic                       w_stuck_nxt;

   logic                       w_rise;
   logic                       w_timeout;
   logic [CW-1:0]              w_per_inc;
   logic [CW-1:0]              w_hi_inc;
   logic [RESOLUTION_BITS-1:0] w_duty_sat;
   logic [RESOLUTION_BITS:0]   w_period_sat;

   assign w_rise    = r_level & ~r_prev;
   // The count reaches TIMEOUT_TICKS on this tick once it is incremented.
   assign w_timeout = (r_per_cnt >= c_TMO_LAST);
   assign w_per_inc = (r_per_cnt == '1) ? r_per_cnt : r_per_cnt + c_CNT_ONE;
   assign w_hi_inc  = (r_hi_cnt  == '1) ? r_hi_cnt  : r_hi_cnt  + c_CNT_ONE;

   assign w_duty_sat   = (32'(r_hi_cnt)  > c_DUTY_MAX) ? '1 : r_hi_cnt[RESOLUTION_BITS-1:0];
   assign w_period_sat = (32'(r_per_cnt) > c_PER_MAX)  ? '1 : r_per_cnt[RESOLUTION_BITS:0];

   always_comb begin
      w_state_nxt  = r_state;
      w_prev_nxt   = r_prev;
      w_per_nxt    = r_per_cnt;
      w_hi_nxt     = r_hi_cnt;
      w_duty_nxt   = r_duty;
      w_period_nxt = r_period;
      w_rdy_nxt    = 1'b0;
      w_stuck_nxt  = r_stuck;
      if (sample_ena) begin
         w_prev_nxt = r_level;
         w_per_nxt  = w_per_inc;
         // A rising edge takes priority over a coincident timeout.
         if (w_rise) begin
            if (r_state == S_LOW) begin
               w_duty_nxt   = w_duty_sat;
               w_period_nxt = w_period_sat;
               w_stuck_nxt  = 1'b0;
               w_rdy_nxt    = 1'b1;
            end
            w_per_nxt   = c_CNT_ONE;
            w_hi_nxt    = c_CNT_ONE;
            w_state_nxt = S_HIGH;
         end else if (w_timeout) begin
            w_duty_nxt   = r_level ? '1 : '0;
            w_period_nxt = '0;
            w_stuck_nxt  = 1'b1;
            w_rdy_nxt    = 1'b1;
            w_per_nxt    = '0;
            w_state_nxt  = S_IDLE;
         end else if (r_state == S_HIGH) begin
            if (r_level) begin
               w_hi_nxt = w_hi_inc;
            end else begin
               w_state_nxt = S_LOW;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync    <= 1'b0;
         r_level   <= 1'b0;
         r_prev    <= 1'b0;
         r_state   <= S_IDLE;
         r_per_cnt <= '0;
         r_hi_cnt  <= '0;
         r_duty    <= '0;
         r_period  <= '0;
         r_rdy     <= 1'b0;
         r_stuck   <= 1'b0;
      end else begin
         r_sync    <= pwm_in;
         r_level   <= r_sync;
         r_prev    <= w_prev_nxt;
         r_state   <= w_state_nxt;
         r_per_cnt <= w_per_nxt;
         r_hi_cnt  <= w_hi_nxt;
         r_duty    <= w_duty_nxt;
         r_period  <= w_period_nxt;
         r_rdy     <= w_rdy_nxt;
         r_stuck   <= w_stuck_nxt;
      end
   end

   assign duty_out   = r_duty;
   assign period_out = r_period;
   assign rdy        = r_rdy;
   assign stuck      = r_stuck;
   assign level      = r_level;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pwm_capture
// Purpose  : Randomised and directed stimulus for pwm_capture, checked every
//            cycle against a tick-index reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm_capture;

   localparam int RES  = 8;
   localparam int TMO  = 511;
   localparam int DMAX = (1 << RES) - 1;
   localparam int PMAX = (1 << (RES + 1)) - 1;

   logic           clk = 1'b0;
   logic           rst;
   logic           pwm_in;
   logic           sample_ena;
   logic [RES-1:0] duty_out;
   logic [RES:0]   period_out;
   logic           rdy;
   logic           stuck;
   logic           level;

   pwm_capture #(.RESOLUTION_BITS(RES), .TIMEOUT_TICKS(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .pwm_in     (pwm_in),
      .sample_ena (sample_ena),
      .duty_out   (duty_out),
      .period_out (period_out),
      .rdy        (rdy),
      .stuck      (stuck),
      .level      (level)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: results derived from tick indices of rising edges,
   // the length of the initial high run, and ticks since the last restart.
   logic m_lv1, m_lv2, m_prev;
   int   m_k, m_base, m_r, m_hi;
   bit   m_run, m_ref;
   logic e_rdy, e_stuck;
   int   e_duty, e_period;
   logic e_level;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_lv1 = 0; m_lv2 = 0; m_prev = 0;
         m_k = 0; m_base = 0; m_r = 0; m_hi = 0; m_run = 0; m_ref = 0;
         e_rdy = 0; e_stuck = 0; e_duty = 0; e_period = 0; e_level = 0;
      end else begin : model_step
         logic lvl;
         lvl   = m_lv2;
         e_rdy = 0;
         m_lv2 = m_lv1;
         m_lv1 = pwm_in;
         if (sample_ena) begin
            m_k++;
            if (lvl && !m_prev) begin
               if (m_ref) begin
                  e_rdy    = 1;
                  e_stuck  = 0;
                  e_duty   = (m_hi > DMAX) ? DMAX : m_hi;
                  e_period = ((m_k - m_r) > PMAX) ? PMAX : (m_k - m_r);
               end
               m_ref = 1; m_r = m_k; m_base = m_k - 1; m_hi = 1; m_run = 1;
            end else if (m_k - m_base >= TMO) begin
               e_rdy = 1; e_stuck = 1; e_period = 0;
               e_duty = lvl ? DMAX : 0;
               m_base = m_k; m_ref = 0; m_run = 0;
            end else if (m_run) begin
               if (lvl) m_hi++;
               else     m_run = 0;
            end
            m_prev = lvl;
         end
         e_level = m_lv2;
      end
   end

   int idx = 0;
   int rdy_cnt, first_duty, first_period, first_idx, last_duty, last_period;
   logic last_stuck;

   always @(posedge clk) begin
      #3;
      check("rdy", rdy, e_rdy);
      check("duty_out", duty_out, e_duty);
      check("period_out", period_out, e_period);
      check("stuck", stuck, e_stuck);
      check("level", level, e_level);
      if (rst) begin
         rdy_cnt = 0;
      end else if (rdy) begin
         rdy_cnt++;
         if (rdy_cnt == 1) begin
            first_duty = duty_out; first_period = period_out; first_idx = idx;
         end
         last_duty = duty_out; last_period = period_out; last_stuck = stuck;
      end
   end

   int div     = 1;
   bit ena_rnd = 0;

   task automatic drive(input logic v);
      @(negedge clk);
      pwm_in = v;
      if (ena_rnd) sample_ena = ($urandom_range(0, 1) == 1);
      else         sample_ena = ((idx % div) == 0);
      idx++;
   endtask

   task automatic pwm(input int per, input int hi, input int n, input int g0, input int glen);
      for (int c = 0; c < n; c++) begin
         for (int o = 0; o < per; o++) begin
            logic v;
            v = (o < hi);
            if (glen > 0 && o >= g0 && o < g0 + glen) v = 1'b0;
            drive(v);
         end
      end
   endtask

   task automatic align(input int m, input int rem);
      while ((idx % m) != rem) drive(1'b0);
   endtask

   task automatic do_reset(input logic v);
      @(negedge clk);
      rst = 1'b1; pwm_in = v; sample_ena = 1'b0;
      #1;
      check("rst_duty", duty_out, 0);
      check("rst_period", period_out, 0);
      check("rst_rdy", rdy, 0);
      check("rst_stuck", stuck, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   int s;

   initial begin
      rst = 1'b1; pwm_in = 1'b0; sample_ena = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // 1: 256/64 with a tick on every clock
      div = 1; ena_rnd = 0;
      do_reset(1'b0); s = idx;
      pwm(256, 64, 3, 0, 0);
      check("s1_rdy_count", rdy_cnt, 2);
      check("s1_first_latency", first_idx - s, 259);
      check("s1_duty", last_duty, 64);
      check("s1_period", last_period, 256);
      check("s1_stuck", last_stuck, 0);

      // 2: constant low line
      do_reset(1'b0); s = idx;
      repeat (1200) drive(1'b0);
      check("s2_rdy_count", rdy_cnt, 2);
      check("s2_first_tick", first_idx - s, 511);
      check("s2_duty", last_duty, 0);
      check("s2_period", last_period, 0);
      check("s2_stuck", last_stuck, 1);

      // 3: constant high, then a live 256/200 signal
      do_reset(1'b0);
      repeat (600) drive(1'b1);
      check("s3_rdy_count_a", rdy_cnt, 1);
      check("s3_duty_a", last_duty, 255);
      check("s3_stuck_a", last_stuck, 1);
      pwm(256, 200, 3, 0, 0);
      check("s3_rdy_count_b", rdy_cnt, 2);
      check("s3_duty_b", last_duty, 200);
      check("s3_period_b", last_period, 256);
      check("s3_stuck_b", last_stuck, 0);

      // 4: tick every 2nd clock
      div = 2;
      do_reset(1'b0); align(2, 0);
      pwm(512, 256, 3, 0, 0);
      check("s4_rdy_count", rdy_cnt, 2);
      check("s4_duty", last_duty, 128);
      check("s4_period", last_period, 256);

      // 5: reset during the high phase
      div = 1;
      do_reset(1'b0);
      pwm(256, 64, 1, 0, 0);
      repeat (30) drive(1'b1);
      check("s5_pre_rdy_count", rdy_cnt, 1);
      check("s5_pre_duty", duty_out, 64);
      do_reset(1'b1);
      repeat (31) drive(1'b1);
      repeat (192) drive(1'b0);
      pwm(256, 64, 3, 0, 0);
      check("s5_rdy_count", rdy_cnt, 3);
      check("s5_duty", last_duty, 64);
      check("s5_period", last_period, 256);

      // 6a: one-clock glitch seen by a tick
      do_reset(1'b0);
      pwm(256, 100, 1, 50, 1);
      pwm(256, 100, 1, 0, 0);
      check("s6a_first_duty", first_duty, 50);
      check("s6a_first_period", first_period, 51);
      check("s6a_rdy_count", rdy_cnt, 2);
      check("s6a_duty", last_duty, 49);
      check("s6a_period", last_period, 205);

      // 6b: two-clock glitch falling between ticks
      div = 4;
      do_reset(1'b0); align(4, 2);
      pwm(256, 100, 3, 41, 2);
      check("s6b_rdy_count", rdy_cnt, 2);
      check("s6b_duty", last_duty, 25);
      check("s6b_period", last_period, 64);

      // 7: edge coincides with timeout; high time saturates
      div = 1;
      do_reset(1'b0);
      pwm(510, 300, 3, 0, 0);
      check("s7_rdy_count", rdy_cnt, 2);
      check("s7_duty", last_duty, 255);
      check("s7_period", last_period, 510);
      check("s7_stuck", last_stuck, 0);

      // Random segments, checked by the model alone
      do_reset(1'b0);
      for (int seg = 0; seg < 14; seg++) begin
         int kind, p, h, g0, gl;
         div     = $urandom_range(1, 3);
         ena_rnd = ($urandom_range(0, 3) == 0);
         kind    = $urandom_range(0, 9);
         if (kind == 0) begin
            repeat ($urandom_range(300, 1100)) drive(logic'($urandom_range(0, 1) == 1 ? 1 : 0) | pwm_in & 1'b0 | (seg[0]));
         end else if (kind == 1) begin
            pwm($urandom_range(20, 200), 10, 1, 0, 0);
            do_reset(logic'($urandom_range(0, 1)));
         end else begin
            p  = $urandom_range(4, 560);
            h  = $urandom_range(0, p);
            gl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            g0 = $urandom_range(0, p);
            pwm(p, h, $urandom_range(1, 3), g0, gl);
         end
      end

      repeat (4) drive(1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
